// File: rtl/lagarto_multihart_rst_seq_pkg.sv
// Shared types and width helpers for the Lagarto multi-hart reset sequencer.
package lagarto_rst_pkg;

    typedef enum logic [2:0] {
        WAKE,
        RELEASE,
        RUN,
        DRAIN,
        HOLD
    } seq_state_e;

    // Width of a counter whose largest value is max_val (never below 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of an index selecting one of n items (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lagarto_multihart_rst_seq_if.sv
// Per-hart control/status bundle between the tile and the reset sequencer.
interface lagarto_multihart_rst_seq_if #(
    parameter int NumHarts = 4
);
    import lagarto_rst_pkg::*;

    localparam int IdxW = idx_width(NumHarts);

    logic [NumHarts-1:0] hart_en_i;
    logic [NumHarts-1:0] soft_rst_req_i;
    logic [NumHarts-1:0] l15_idle_i;
    logic [NumHarts-1:0] hart_rst_no;
    logic                seq_done_o;
    logic                busy_o;
    logic                timeout_o;
    logic [IdxW-1:0]     timeout_hart_o;

    modport master (
        output hart_en_i, soft_rst_req_i, l15_idle_i,
        input  hart_rst_no, seq_done_o, busy_o, timeout_o, timeout_hart_o
    );

    modport slave (
        input  hart_en_i, soft_rst_req_i, l15_idle_i,
        output hart_rst_no, seq_done_o, busy_o, timeout_o, timeout_hart_o
    );

endinterface

// File: rtl/lagarto_multihart_rst_seq_sync.sv
// Per-hart reset output chain: SyncStages flops with a synchronous clear.
module lagarto_rst_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < SyncStages; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[SyncStages-1];

endmodule

// File: rtl/lagarto_multihart_rst_seq.sv
// Multi-hart reset sequencer: power-on wake delay, staggered release,
// hot-plug masking and drained per-hart soft reset.
module lagarto_multihart_rst_seq
    import lagarto_rst_pkg::*;
#(
    parameter int NumHarts      = 4,
    parameter int WakeCycles    = 32768,
    parameter int StaggerCycles = 8,
    parameter int SyncStages    = 2,
    parameter int DrainTimeout  = 1024,
    parameter int HoldCycles    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    lagarto_multihart_rst_seq_if.slave seq
);

    localparam int WakeW  = cnt_width(WakeCycles);
    localparam int SlotW  = cnt_width(StaggerCycles - 1);
    localparam int RelW   = cnt_width(NumHarts);
    localparam int DrainW = cnt_width(DrainTimeout - 1);
    localparam int HoldW  = cnt_width(HoldCycles - 1);
    localparam int IdxW   = idx_width(NumHarts);

    seq_state_e          state_q, state_d;
    logic [WakeW-1:0]    wake_cnt_q, wake_cnt_d;
    logic [SlotW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [RelW-1:0]     rel_idx_q, rel_idx_d;
    logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [NumHarts-1:0] raw_q, raw_d;
    logic [NumHarts-1:0] pending_q, pending_d;
    logic [IdxW-1:0]     svc_idx_q, svc_idx_d;
    logic                seq_done_q, seq_done_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic [IdxW-1:0]     timeout_hart_q, timeout_hart_d;

    logic [NumHarts-1:0] new_req;
    logic [NumHarts-1:0] svc_mask;
    logic [NumHarts-1:0] rest;
    logic                svc_idle;

    function automatic logic [IdxW-1:0] lowest_idx(input logic [NumHarts-1:0] v);
        logic [IdxW-1:0] r;
        r = '0;
        for (int i = NumHarts - 1; i >= 0; i--) begin
            if (v[i]) r = IdxW'(i);
        end
        return r;
    endfunction

    assign new_req  = seq.soft_rst_req_i & seq.hart_en_i;
    assign svc_mask = NumHarts'(1) << svc_idx_q;
    assign svc_idle = |(seq.l15_idle_i & svc_mask);

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path infers a latch.
        state_d        = state_q;
        wake_cnt_d     = wake_cnt_q;
        slot_cnt_d     = slot_cnt_q;
        rel_idx_d      = rel_idx_q;
        drain_cnt_d    = drain_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        raw_d          = raw_q;
        pending_d      = pending_q;
        svc_idx_d      = svc_idx_q;
        seq_done_d     = seq_done_q;
        timeout_d      = 1'b0;
        timeout_hart_d = timeout_hart_q;
        rest           = '0;

        unique case (state_q)
            WAKE: begin
                if (wake_cnt_q != WakeW'(WakeCycles)) wake_cnt_d = wake_cnt_q + 1'b1;
                if (wake_cnt_q == WakeW'(WakeCycles - 1)) state_d = RELEASE;
            end
            RELEASE: begin
                slot_cnt_d = (slot_cnt_q == SlotW'(StaggerCycles - 1)) ? '0 : slot_cnt_q + 1'b1;
                if (slot_cnt_q == '0) begin
                    // Disabled harts still burn their slot so release timing is fixed.
                    for (int i = 0; i < NumHarts; i++) begin
                        if (rel_idx_q == RelW'(i)) raw_d[i] = seq.hart_en_i[i];
                    end
                    if (rel_idx_q != RelW'(NumHarts)) rel_idx_d = rel_idx_q + 1'b1;
                    if (rel_idx_q == RelW'(NumHarts - 1)) begin
                        seq_done_d = 1'b1;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                raw_d     = seq.hart_en_i;
                pending_d = pending_q | new_req;
                if (|pending_d) begin
                    svc_idx_d   = lowest_idx(pending_d);
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                pending_d = pending_q | new_req;
                raw_d     = (seq.hart_en_i & ~svc_mask) | (raw_q & svc_mask);
                if (drain_cnt_q != DrainW'(DrainTimeout - 1)) drain_cnt_d = drain_cnt_q + 1'b1;
                if (svc_idle || drain_cnt_q == DrainW'(DrainTimeout - 1)) begin
                    timeout_d      = !svc_idle;
                    timeout_hart_d = svc_idle ? timeout_hart_q : svc_idx_q;
                    raw_d          = raw_d & ~svc_mask;
                    hold_cnt_d     = '0;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                pending_d = pending_q | new_req;
                raw_d     = (seq.hart_en_i & ~svc_mask) | (raw_q & svc_mask);
                if (hold_cnt_q != HoldW'(HoldCycles - 1)) hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HoldW'(HoldCycles - 1)) begin
                    raw_d     = seq.hart_en_i & svc_mask | (raw_d & ~svc_mask);
                    rest      = (pending_q | new_req) & ~svc_mask;
                    pending_d = rest;
                    // Chain straight into the next queued hart so busy_o never gaps.
                    if (|rest) begin
                        svc_idx_d   = lowest_idx(rest);
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = WAKE;
        endcase

        busy_d = (state_d == DRAIN) || (state_d == HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= WAKE;
            wake_cnt_q     <= '0;
            slot_cnt_q     <= '0;
            rel_idx_q      <= '0;
            drain_cnt_q    <= '0;
            hold_cnt_q     <= '0;
            raw_q          <= '0;
            pending_q      <= '0;
            svc_idx_q      <= '0;
            seq_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
            timeout_hart_q <= '0;
        end else begin
            state_q        <= state_d;
            wake_cnt_q     <= wake_cnt_d;
            slot_cnt_q     <= slot_cnt_d;
            rel_idx_q      <= rel_idx_d;
            drain_cnt_q    <= drain_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            raw_q          <= raw_d;
            pending_q      <= pending_d;
            svc_idx_q      <= svc_idx_d;
            seq_done_q     <= seq_done_d;
            busy_q         <= busy_d;
            timeout_q      <= timeout_d;
            timeout_hart_q <= timeout_hart_d;
        end
    end

    for (genvar g = 0; g < NumHarts; g++) begin : g_sync
        lagarto_rst_sync #(.SyncStages(SyncStages)) u_sync (
            .clk_i (clk_i),
            .clr_i (rst_i),
            .d_i   (raw_q[g]),
            .q_o   (seq.hart_rst_no[g])
        );
    end

    assign seq.seq_done_o     = seq_done_q;
    assign seq.busy_o         = busy_q;
    assign seq.timeout_o      = timeout_q;
    assign seq.timeout_hart_o = timeout_hart_q;

endmodule

// File: tb/tb_lagarto_multihart_rst_seq.sv
// Directed bench for the multi-hart reset sequencer; edge_n counts rising
// edges since the last reset release, checks sample 1 time unit after an edge.
module tb_lagarto_multihart_rst_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   edge_n;

    lagarto_multihart_rst_seq_if #(.NumHarts(4)) bus ();

    lagarto_multihart_rst_seq #(
        .NumHarts      (4),
        .WakeCycles    (16),
        .StaggerCycles (4),
        .SyncStages    (2),
        .DrainTimeout  (8),
        .HoldCycles    (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .seq   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic apply_reset(input logic [3:0] en);
        rst                = 1'b1;
        bus.hart_en_i      = en;
        bus.soft_rst_req_i = '0;
        bus.l15_idle_i     = '1;
        tick();
        tick();
        check("rst_hart_rst_no", 32'(bus.hart_rst_no), 32'h0);
        check("rst_seq_done", 32'(bus.seq_done_o), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_timeout", 32'(bus.timeout_o), 32'h0);
        check("rst_timeout_hart", 32'(bus.timeout_hart_o), 32'h0);
        rst    = 1'b0;
        edge_n = -1;
    endtask

    task automatic power_up_full();
        goto_edge(15); check("pu_wake", 32'(bus.hart_rst_no), 32'h0);
        goto_edge(17); check("pu_pre_h0", 32'(bus.hart_rst_no), 32'h0);
        goto_edge(18); check("pu_h0", 32'(bus.hart_rst_no), 32'h1);
        goto_edge(21); check("pu_pre_h1", 32'(bus.hart_rst_no), 32'h1);
        goto_edge(22); check("pu_h1", 32'(bus.hart_rst_no), 32'h3);
        goto_edge(26); check("pu_h2", 32'(bus.hart_rst_no), 32'h7);
        goto_edge(27); check("pu_done_early", 32'(bus.seq_done_o), 32'h0);
        goto_edge(28); check("pu_done", 32'(bus.seq_done_o), 32'h1);
        check("pu_h2_hold", 32'(bus.hart_rst_no), 32'h7);
        goto_edge(29); check("pu_pre_h3", 32'(bus.hart_rst_no), 32'h7);
        goto_edge(30); check("pu_h3", 32'(bus.hart_rst_no), 32'hF);
        check("pu_busy", 32'(bus.busy_o), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;

        // Masked power-up: only harts 1 and 3 enabled.
        apply_reset(4'b1010);
        goto_edge(21); check("mask_pre_h1", 32'(bus.hart_rst_no), 32'h0);
        goto_edge(22); check("mask_h1", 32'(bus.hart_rst_no), 32'h2);
        goto_edge(27); check("mask_done_early", 32'(bus.seq_done_o), 32'h0);
        goto_edge(28); check("mask_done", 32'(bus.seq_done_o), 32'h1);
        goto_edge(30); check("mask_h3", 32'(bus.hart_rst_no), 32'hA);

        // Hot-plug harts 0 and 2 while in RUN.
        goto_edge(31); bus.hart_en_i = 4'hF;
        goto_edge(33); check("hotplug_lag", 32'(bus.hart_rst_no), 32'hA);
        goto_edge(34); check("hotplug", 32'(bus.hart_rst_no), 32'hF);

        // Soft reset of hart 2 with an idle L1.5.
        bus.soft_rst_req_i = 4'b0100;
        tick(); bus.soft_rst_req_i = '0;
        check("sr2_busy", 32'(bus.busy_o), 32'h1);
        goto_edge(36); check("sr2_no_timeout", 32'(bus.timeout_o), 32'h0);
        goto_edge(37); check("sr2_lag", 32'(bus.hart_rst_no), 32'hF);
        goto_edge(38); check("sr2_low_first", 32'(bus.hart_rst_no), 32'hB);
        check("sr2_busy_hold", 32'(bus.busy_o), 32'h1);
        goto_edge(39); check("sr2_busy_exit", 32'(bus.busy_o), 32'h0);
        goto_edge(40); check("sr2_low_last", 32'(bus.hart_rst_no), 32'hB);
        goto_edge(41); check("sr2_release", 32'(bus.hart_rst_no), 32'hF);

        // Soft reset of hart 1 with a never-idle L1.5: drain times out.
        bus.l15_idle_i     = 4'h0;
        bus.soft_rst_req_i = 4'b0010;
        tick(); bus.soft_rst_req_i = '0;
        goto_edge(49); check("sr1_pre_timeout", 32'(bus.timeout_o), 32'h0);
        check("sr1_still_up", 32'(bus.hart_rst_no), 32'hF);
        goto_edge(50); check("sr1_timeout", 32'(bus.timeout_o), 32'h1);
        check("sr1_timeout_hart", 32'(bus.timeout_hart_o), 32'h1);
        goto_edge(51); check("sr1_timeout_pulse", 32'(bus.timeout_o), 32'h0);
        goto_edge(52); check("sr1_low_first", 32'(bus.hart_rst_no), 32'hD);
        goto_edge(54); check("sr1_low_last", 32'(bus.hart_rst_no), 32'hD);
        goto_edge(55); check("sr1_release", 32'(bus.hart_rst_no), 32'hF);

        // Simultaneous requests for harts 0 and 3: index order, busy unbroken.
        bus.l15_idle_i     = 4'hF;
        bus.soft_rst_req_i = 4'b1001;
        tick(); bus.soft_rst_req_i = '0;
        check("dual_busy_start", 32'(bus.busy_o), 32'h1);
        goto_edge(59); check("dual_h0_low", 32'(bus.hart_rst_no), 32'hE);
        goto_edge(60); check("dual_busy_switch", 32'(bus.busy_o), 32'h1);
        goto_edge(61); check("dual_h0_low_last", 32'(bus.hart_rst_no), 32'hE);
        check("dual_busy_h3", 32'(bus.busy_o), 32'h1);
        goto_edge(62); check("dual_h0_up", 32'(bus.hart_rst_no), 32'hF);
        goto_edge(63); check("dual_h3_low", 32'(bus.hart_rst_no), 32'h7);
        check("dual_busy_end_hold", 32'(bus.busy_o), 32'h1);
        goto_edge(64); check("dual_busy_drop", 32'(bus.busy_o), 32'h0);
        goto_edge(65); check("dual_h3_low_last", 32'(bus.hart_rst_no), 32'h7);
        goto_edge(66); check("dual_h3_up", 32'(bus.hart_rst_no), 32'hF);

        // Reset arriving mid-HOLD clears everything, then full power-up replays.
        bus.soft_rst_req_i = 4'b0100;
        tick(); bus.soft_rst_req_i = '0;
        goto_edge(69); check("midhold_busy", 32'(bus.busy_o), 32'h1);
        rst = 1'b1;
        tick();
        check("midhold_rst_outputs", 32'(bus.hart_rst_no), 32'h0);
        check("midhold_rst_busy", 32'(bus.busy_o), 32'h0);
        check("midhold_rst_done", 32'(bus.seq_done_o), 32'h0);
        check("midhold_rst_thart", 32'(bus.timeout_hart_o), 32'h0);
        rst    = 1'b0;
        edge_n = -1;
        power_up_full();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
